// File: rtl/flash_arbiter_pkg.sv
// Shared definitions for the flash arbiter: load op codes, flash commands, FSM states.
package flash_arbiter_pkg;

    typedef enum logic [2:0] {
        MEM_LB  = 3'd0,
        MEM_LBU = 3'd1,
        MEM_LH  = 3'd2,
        MEM_LHU = 3'd3,
        MEM_LW  = 3'd4
    } mem_op_t;

    localparam logic [15:0] FLASH_CMD_READ_ARRAY = 16'h00FF;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CMD_WE   = 3'd1,
        ST_CMD_HOLD = 3'd2,
        ST_RD_LO    = 3'd3,
        ST_RD_HI    = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_t;

    function automatic logic is_word_op(input logic [2:0] op);
        return op == MEM_LW;
    endfunction

endpackage

// File: rtl/flash_arbiter_if.sv
// Requester-side bundle: IF fetch port, MEM load port and the pipeline pause request.
interface flash_arbiter_if #(
    parameter int ADDR_W = 23
);
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic [31:0]       if_rdata_o;
    logic              if_ack_o;

    logic              mem_req_i;
    logic [ADDR_W-1:0] mem_addr_i;
    logic [2:0]        mem_op_i;
    logic [31:0]       mem_rdata_o;
    logic              mem_ack_o;

    logic              pause_o;

    modport master (
        output if_req_i, if_addr_i, mem_req_i, mem_addr_i, mem_op_i,
        input  if_rdata_o, if_ack_o, mem_rdata_o, mem_ack_o, pause_o
    );

    modport slave (
        input  if_req_i, if_addr_i, mem_req_i, mem_addr_i, mem_op_i,
        output if_rdata_o, if_ack_o, mem_rdata_o, mem_ack_o, pause_o
    );
endinterface

// File: rtl/flash_load_ext.sv
// Combinational load formatter: builds a 32-bit result from two halfwords per load op.
module flash_load_ext
    import flash_arbiter_pkg::*;
(
    input  logic [2:0]  op,
    input  logic        addr0,
    input  logic [15:0] lo,
    input  logic [15:0] hi,
    output logic [31:0] data
);

    function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
        logic signed [15:0] hs;
        logic signed [31:0] ws;
        hs = signed'(h);
        ws = hs;
        return sgn ? unsigned'(ws) : {16'h0000, h};
    endfunction

    function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
        logic signed [7:0]  bs;
        logic signed [31:0] ws;
        bs = signed'(b);
        ws = bs;
        return sgn ? unsigned'(ws) : {24'h000000, b};
    endfunction

    logic [7:0] byte_sel;

    always_comb begin
        byte_sel = addr0 ? lo[15:8] : lo[7:0];
        case (op)
            MEM_LW:  data = {hi, lo};
            MEM_LH:  data = ext16(lo, 1'b1);
            MEM_LB:  data = ext8(byte_sel, 1'b1);
            MEM_LBU: data = ext8(byte_sel, 1'b0);
            // LHU and any unrecognised encoding
            default: data = ext16(lo, 1'b0);
        endcase
    end

endmodule

// File: rtl/flash_arbiter.sv
// Round-robin arbiter sharing the 16-bit board flash between instruction fetch and MEM loads.
module flash_arbiter
    import flash_arbiter_pkg::*;
#(
    parameter int WAIT_CYCLES = 4,
    parameter int ADDR_W      = 23
) (
    input  logic              clk,
    input  logic              rst,
    flash_arbiter_if.slave    bus,
    output logic [ADDR_W-1:0] flash_addr_o,
    output logic [15:0]       flash_wdata_o,
    output logic              flash_wdata_oe_o,
    input  logic [15:0]       flash_rdata_i,
    output logic              flash_ce_n_o,
    output logic              flash_we_n_o,
    output logic              flash_oe_n_o,
    output logic              flash_byte_n_o,
    output logic              flash_rp_n_o
);

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

    state_t            state, state_n;
    owner_t            owner, owner_n;
    owner_t            last_grant, last_grant_n;
    logic              cmd_done, cmd_done_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [2:0]        op_q, op_n;
    logic [3:0]        wait_cnt, wait_n;
    logic [15:0]       lo_q, lo_n, hi_q, hi_n;

    logic [ADDR_W-1:0] flash_addr_n;
    logic [15:0]       flash_wdata_n;
    logic              flash_wdata_oe_n, ce_n_n, we_n_n, oe_n_n;
    logic              if_ack_q, if_ack_n, mem_ack_q, mem_ack_n;
    logic [31:0]       if_rdata_q, if_rdata_n, mem_rdata_q, mem_rdata_n;

    logic              gnt_if, gnt_mem;
    logic [31:0]       ext_data;

    // On a tie the port that lost the previous grant wins.
    assign gnt_mem = bus.mem_req_i & (~bus.if_req_i | (last_grant == OWN_IF));
    assign gnt_if  = bus.if_req_i & ~gnt_mem;

    flash_load_ext u_ext (
        .op    (op_n),
        .addr0 (addr_n[0]),
        .lo    (lo_n),
        .hi    (hi_n),
        .data  (ext_data)
    );

    always_comb begin
        state_n      = state;
        owner_n      = owner;
        last_grant_n = last_grant;
        cmd_done_n   = cmd_done;
        addr_n       = addr_q;
        op_n         = op_q;
        wait_n       = wait_cnt;
        lo_n         = lo_q;
        hi_n         = hi_q;

        case (state)
            ST_IDLE: begin
                if (gnt_if | gnt_mem) begin
                    owner_n      = gnt_mem ? OWN_MEM : OWN_IF;
                    last_grant_n = owner_n;
                    addr_n       = gnt_mem ? bus.mem_addr_i : bus.if_addr_i;
                    op_n         = gnt_mem ? bus.mem_op_i : MEM_LW;
                    wait_n       = 4'd0;
                    state_n      = cmd_done ? ST_RD_LO : ST_CMD_WE;
                end
            end
            ST_CMD_WE: state_n = ST_CMD_HOLD;
            ST_CMD_HOLD: begin
                cmd_done_n = 1'b1;
                state_n    = ST_RD_LO;
            end
            ST_RD_LO: begin
                if (wait_cnt == WAIT_LAST) begin
                    lo_n    = flash_rdata_i;
                    wait_n  = 4'd0;
                    state_n = is_word_op(op_q) ? ST_RD_HI : ST_DONE;
                end else begin
                    wait_n = wait_cnt + 4'd1;
                end
            end
            ST_RD_HI: begin
                if (wait_cnt == WAIT_LAST) begin
                    hi_n    = flash_rdata_i;
                    wait_n  = 4'd0;
                    state_n = ST_DONE;
                end else begin
                    wait_n = wait_cnt + 4'd1;
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase

        // Outputs are registered, so decode them from the state being entered.
        ce_n_n           = !(state_n inside {ST_CMD_WE, ST_CMD_HOLD, ST_RD_LO, ST_RD_HI});
        we_n_n           = !(state_n == ST_CMD_WE);
        oe_n_n           = !(state_n inside {ST_RD_LO, ST_RD_HI});
        flash_wdata_oe_n = state_n inside {ST_CMD_WE, ST_CMD_HOLD};
        flash_wdata_n    = flash_wdata_oe_n ? FLASH_CMD_READ_ARRAY : 16'h0000;

        flash_addr_n = flash_addr_o;
        if (state_n == ST_RD_LO) begin
            flash_addr_n = is_word_op(op_n) ? {addr_n[ADDR_W-1:2], 2'b00}
                                            : {addr_n[ADDR_W-1:1], 1'b0};
        end else if (state_n == ST_RD_HI) begin
            flash_addr_n = {addr_n[ADDR_W-1:2], 2'b10};
        end

        if_ack_n    = (state_n == ST_DONE) && (owner_n == OWN_IF);
        mem_ack_n   = (state_n == ST_DONE) && (owner_n == OWN_MEM);
        if_rdata_n  = if_ack_n  ? ext_data : 32'h0;
        mem_rdata_n = mem_ack_n ? ext_data : 32'h0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= ST_IDLE;
            owner            <= OWN_IF;
            last_grant       <= OWN_IF;
            cmd_done         <= 1'b0;
            addr_q           <= '0;
            op_q             <= 3'd0;
            wait_cnt         <= 4'd0;
            lo_q             <= 16'h0;
            hi_q             <= 16'h0;
            flash_addr_o     <= '0;
            flash_wdata_o    <= 16'h0;
            flash_wdata_oe_o <= 1'b0;
            flash_ce_n_o     <= 1'b1;
            flash_we_n_o     <= 1'b1;
            flash_oe_n_o     <= 1'b1;
            if_ack_q         <= 1'b0;
            mem_ack_q        <= 1'b0;
            if_rdata_q       <= 32'h0;
            mem_rdata_q      <= 32'h0;
        end else begin
            state            <= state_n;
            owner            <= owner_n;
            last_grant       <= last_grant_n;
            cmd_done         <= cmd_done_n;
            addr_q           <= addr_n;
            op_q             <= op_n;
            wait_cnt         <= wait_n;
            lo_q             <= lo_n;
            hi_q             <= hi_n;
            flash_addr_o     <= flash_addr_n;
            flash_wdata_o    <= flash_wdata_n;
            flash_wdata_oe_o <= flash_wdata_oe_n;
            flash_ce_n_o     <= ce_n_n;
            flash_we_n_o     <= we_n_n;
            flash_oe_n_o     <= oe_n_n;
            if_ack_q         <= if_ack_n;
            mem_ack_q        <= mem_ack_n;
            if_rdata_q       <= if_rdata_n;
            mem_rdata_q      <= mem_rdata_n;
        end
    end

    assign bus.if_ack_o    = if_ack_q;
    assign bus.mem_ack_o   = mem_ack_q;
    assign bus.if_rdata_o  = if_rdata_q;
    assign bus.mem_rdata_o = mem_rdata_q;
    assign bus.pause_o     = (bus.if_req_i & ~if_ack_q) | (bus.mem_req_i & ~mem_ack_q);

    assign flash_byte_n_o = 1'b1;
    assign flash_rp_n_o   = 1'b1;

endmodule

// File: tb/tb_flash_arbiter.sv
// Directed bench for flash_arbiter with a behavioural flash model and immediate-assertion checks.
module tb_flash_arbiter;
    import flash_arbiter_pkg::*;

    localparam int ADDR_W = 23;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [ADDR_W-1:0] flash_addr;
    logic [15:0]       flash_wdata;
    logic              flash_wdata_oe;
    logic [15:0]       flash_rdata;
    logic              flash_ce_n, flash_we_n, flash_oe_n, flash_byte_n, flash_rp_n;

    int checks = 0;
    int errors = 0;

    flash_arbiter_if #(.ADDR_W(ADDR_W)) bif ();

    flash_arbiter #(.WAIT_CYCLES(4), .ADDR_W(ADDR_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bif),
        .flash_addr_o     (flash_addr),
        .flash_wdata_o    (flash_wdata),
        .flash_wdata_oe_o (flash_wdata_oe),
        .flash_rdata_i    (flash_rdata),
        .flash_ce_n_o     (flash_ce_n),
        .flash_we_n_o     (flash_we_n),
        .flash_oe_n_o     (flash_oe_n),
        .flash_byte_n_o   (flash_byte_n),
        .flash_rp_n_o     (flash_rp_n)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] flash_word(input logic [ADDR_W-1:0] a);
        case (a)
            23'h000100: return 16'h1234;
            23'h000102: return 16'hABCD;
            23'h000104: return 16'h5678;
            23'h000106: return 16'h9ABC;
            23'h000200: return 16'h80FF;
            default:    return a[15:0] ^ 16'h5A5A;
        endcase
    endfunction

    assign flash_rdata = (!flash_ce_n && !flash_oe_n) ? flash_word(flash_addr) : 16'hDEAD;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues one request, scrambles addr/op after the grant edge, waits (bounded) for the ack.
    task automatic do_read(input bit use_mem, input logic [ADDR_W-1:0] addr, input logic [2:0] op,
                           output int lat, output logic [31:0] data, output logic [31:0] other,
                           output int cmds, output logic [15:0] cmd_data);
        lat = -1; data = '0; other = '0; cmds = 0; cmd_data = '0;
        if (use_mem) begin
            bif.mem_req_i = 1'b1; bif.mem_addr_i = addr; bif.mem_op_i = op;
        end else begin
            bif.if_req_i = 1'b1; bif.if_addr_i = addr;
        end
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk); #1;
            if (n == 1) begin
                bif.if_addr_i = 23'h7FFFFE; bif.mem_addr_i = 23'h7FFFFE; bif.mem_op_i = MEM_LW;
            end
            if (!flash_we_n) begin cmds++; cmd_data = flash_wdata; end
            if (use_mem ? bif.mem_ack_o : bif.if_ack_o) begin
                lat   = n;
                data  = use_mem ? bif.mem_rdata_o : bif.if_rdata_o;
                other = use_mem ? bif.if_rdata_o : bif.mem_rdata_o;
                break;
            end
        end
        bif.if_req_i = 1'b0; bif.mem_req_i = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    int          lat, cmds, acks, pause_low, ack_cnt;
    logic [31:0] data, other;
    logic [15:0] cmd_data;
    logic [3:0]  seq;

    initial begin
        bif.if_req_i = 1'b0; bif.if_addr_i = '0;
        bif.mem_req_i = 1'b0; bif.mem_addr_i = '0; bif.mem_op_i = MEM_LB;

        #3 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_strobes", {28'h0, flash_ce_n, flash_we_n, flash_oe_n, flash_wdata_oe}, 32'hE);
        check("rst_tied", {30'h0, flash_byte_n, flash_rp_n}, 32'h3);
        check("rst_acks", {30'h0, bif.if_ack_o, bif.mem_ack_o}, 32'h0);
        check("rst_rdata", bif.if_rdata_o | bif.mem_rdata_o, 32'h0);
        check("rst_addr_wdata", {9'h0, flash_addr} | {16'h0, flash_wdata}, 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;

        do_read(1'b0, 23'h000100, MEM_LW, lat, data, other, cmds, cmd_data);
        check("if_first_data", data, 32'hABCD1234);
        check("if_first_lat", 32'(lat), 32'd11);
        check("if_first_cmds", 32'(cmds), 32'd1);
        check("if_first_cmd_data", {16'h0, cmd_data}, 32'h000000FF);
        check("if_first_other", other, 32'h0);
        @(posedge clk); #1;

        do_read(1'b0, 23'h000104, MEM_LW, lat, data, other, cmds, cmd_data);
        check("if_second_data", data, 32'h9ABC5678);
        check("if_second_lat", 32'(lat), 32'd9);
        check("if_second_cmds", 32'(cmds), 32'd0);
        @(posedge clk); #1;

        do_read(1'b0, 23'h000107, MEM_LW, lat, data, other, cmds, cmd_data);
        check("if_low_bits_ignored", data, 32'h9ABC5678);
        @(posedge clk); #1;

        do_read(1'b1, 23'h000201, MEM_LB, lat, data, other, cmds, cmd_data);
        check("mem_lb_data", data, 32'hFFFFFF80);
        check("mem_lb_lat", 32'(lat), 32'd5);
        check("mem_lb_other", other, 32'h0);
        @(posedge clk); #1;
        do_read(1'b1, 23'h000201, MEM_LBU, lat, data, other, cmds, cmd_data);
        check("mem_lbu_data", data, 32'h00000080);
        @(posedge clk); #1;
        do_read(1'b1, 23'h000200, MEM_LH, lat, data, other, cmds, cmd_data);
        check("mem_lh_data", data, 32'hFFFF80FF);
        @(posedge clk); #1;
        do_read(1'b1, 23'h000200, MEM_LHU, lat, data, other, cmds, cmd_data);
        check("mem_lhu_data", data, 32'h000080FF);
        @(posedge clk); #1;
        do_read(1'b1, 23'h000200, MEM_LB, lat, data, other, cmds, cmd_data);
        check("mem_lb_even", data, 32'hFFFFFFFF);
        @(posedge clk); #1;
        do_read(1'b1, 23'h000200, 3'd7, lat, data, other, cmds, cmd_data);
        check("mem_unknown_op", data, 32'h000080FF);
        check("mem_unknown_lat", 32'(lat), 32'd5);
        @(posedge clk); #1;
        do_read(1'b1, 23'h000100, MEM_LW, lat, data, other, cmds, cmd_data);
        check("mem_lw_data", data, 32'hABCD1234);
        check("mem_lw_lat", 32'(lat), 32'd9);
        @(posedge clk); #1;

        // Simultaneous requests after reset; hold both and record the grant order.
        apply_reset();
        bif.if_addr_i = 23'h000100; bif.mem_addr_i = 23'h000200; bif.mem_op_i = MEM_LH;
        bif.if_req_i = 1'b1; bif.mem_req_i = 1'b1;
        acks = 0; pause_low = 0; seq = 4'h0;
        for (int n = 0; n < 200 && acks < 4; n++) begin
            @(posedge clk); #1;
            if (!bif.pause_o) pause_low++;
            if (bif.if_ack_o && bif.mem_ack_o) pause_low += 100;
            if (bif.mem_ack_o && acks == 0) check("rr_first_mem_data", bif.mem_rdata_o, 32'hFFFF80FF);
            if (bif.if_ack_o || bif.mem_ack_o) begin
                seq[acks] = bif.if_ack_o;
                acks++;
            end
        end
        bif.if_req_i = 1'b0; bif.mem_req_i = 1'b0;
        check("rr_ack_count", 32'(acks), 32'd4);
        check("rr_order", {28'h0, seq}, 32'hA);
        check("rr_pause_held", 32'(pause_low), 32'd0);
        @(posedge clk); #1;
        check("pause_idle", {31'h0, bif.pause_o}, 32'h0);

        // Reset asserted while the high halfword is being read.
        bif.if_addr_i = 23'h000100; bif.if_req_i = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("rdhi_oe_low", {31'h0, flash_oe_n}, 32'h0);
        check("rdhi_addr", {9'h0, flash_addr}, 32'h00000102);
        bif.if_req_i = 1'b0;
        rst = 1'b0;
        #1;
        check("midrst_strobes", {28'h0, flash_ce_n, flash_we_n, flash_oe_n, flash_wdata_oe}, 32'hE);
        check("midrst_acks_addr", {8'h0, bif.if_ack_o, bif.mem_ack_o, flash_addr}, 32'h0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        do_read(1'b0, 23'h000100, MEM_LW, lat, data, other, cmds, cmd_data);
        check("postrst_cmds", 32'(cmds), 32'd1);
        check("postrst_lat", 32'(lat), 32'd11);
        check("postrst_data", data, 32'hABCD1234);
        @(posedge clk); #1;

        // Requester withdraws during RD_LO; the transaction still completes once.
        bif.if_addr_i = 23'h000104; bif.if_req_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("drop_in_rdlo", {31'h0, flash_oe_n}, 32'h0);
        bif.if_req_i = 1'b0;
        ack_cnt = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bif.if_ack_o) ack_cnt++;
        end
        check("drop_ack_once", 32'(ack_cnt), 32'd1);
        check("drop_strobes_idle", {30'h0, flash_ce_n, flash_oe_n}, 32'h3);
        do_read(1'b1, 23'h000201, MEM_LBU, lat, data, other, cmds, cmd_data);
        check("drop_then_mem_lat", 32'(lat), 32'd5);
        check("drop_then_mem_data", data, 32'h00000080);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/flash_arbiter.md
Name: flash_arbiter

Overview:
- Shares the single 16-bit board flash between two read requesters: instruction fetch (IF port) and the MEM-stage load path (MEM port).
- Sequences the flash bus: a one-time read-array command (0x00FF), then OE-timed word reads.
- Assembles 32-bit words from two halfword reads and sign- or zero-extends sub-word loads.
- Sits between the pipeline/MMU and the flash pins, and drives a pause request to the pipeline controller.

Parameters:
- WAIT_CYCLES, 4, number of cycles OE is held low per halfword read; data is sampled on the last of these cycles; legal range 1..15.
- ADDR_W, 23, byte-address width of both request ports and the flash address bus.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- if_req_i  in  1  IF read request; requester holds it until if_ack_o.
- if_addr_i  in  ADDR_W  IF byte address; always a word read, bits [1:0] ignored.
- if_rdata_o  out  32  IF read data; valid while if_ack_o=1.
- if_ack_o  out  1  one-cycle completion pulse for IF.
- mem_req_i  in  1  MEM read request; held until mem_ack_o.
- mem_addr_i  in  ADDR_W  MEM byte address.
- mem_op_i  in  3  MEM_LB/LBU/LH/LHU/LW encoding from defines.v.
- mem_rdata_o  out  32  extended MEM read data; valid while mem_ack_o=1.
- mem_ack_o  out  1  one-cycle completion pulse for MEM.
- pause_o  out  1  (if_req_i & ~if_ack_o) | (mem_req_i & ~mem_ack_o); combinational.
- flash_addr_o  out  ADDR_W  flash byte address; bit 0 is always 0.
- flash_wdata_o  out  16  command data.
- flash_wdata_oe_o  out  1  data-bus drive enable; the top level tristates the bus when this is 0.
- flash_rdata_i  in  16  flash data bus input.
- flash_ce_n_o, flash_we_n_o, flash_oe_n_o  out  1 each  active-low flash strobes.
- flash_byte_n_o, flash_rp_n_o  out  1 each  tied to 1: 16-bit mode, not in reset-powerdown.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, cmd_done=0, last_grant=IF.
  - All strobes = 1; flash_wdata_oe_o=0; flash_wdata_o=0; flash_addr_o=0.
  - Both acks = 0; both rdata outputs = 0; wait counter = 0.
- Registered outputs: all outputs except pause_o.
- States: IDLE, CMD_WE, CMD_HOLD, RD_LO, RD_HI, DONE.
- IDLE:
  - If any request is pending, grant it, latch address/op/owner into registers, and set ce_n=0.
  - Next state is CMD_WE if cmd_done=0; otherwise RD_LO.
- Arbitration:
  - With a single requester, it wins.
  - If both are pending, the port that did not win the previous grant wins (round-robin). After reset, MEM wins the first tie.
- CMD_WE (1 cycle): we_n=0, wdata_oe=1, wdata=0x00FF.
- CMD_HOLD (1 cycle): we_n=1, wdata still driven. Then set cmd_done=1 and go to RD_LO. cmd_done is cleared only by reset.
- RD_LO:
  - oe_n=0, wdata_oe=0.
  - flash_addr_o = {addr[ADDR_W-1:1],0}, except LW/IF, which use {addr[ADDR_W-1:2],2'b00}.
  - Hold for WAIT_CYCLES cycles, then capture flash_rdata_i into lo.
  - Next: RD_HI for LW/IF, else DONE.
- RD_HI:
  - oe_n stays 0; flash_addr_o = {addr[ADDR_W-1:2],2'b10}.
  - Hold for WAIT_CYCLES cycles, capture into hi, go to DONE.
- DONE (1 cycle):
  - ce_n=1, oe_n=1.
  - Pulse the owner's ack and drive its rdata; the non-owner's rdata stays 0.
  - Return to IDLE. A new grant is possible on the following cycle.
- Data formatting (little-endian):
  - LW/IF = {hi,lo}.
  - LH: sign-extend lo; LHU: zero-extend lo.
  - LB/LBU: take lo[7:0] if addr[0]=0, else lo[15:8]; LB sign-extends, LBU zero-extends.
  - Unknown op is treated as LHU.
- Latency, counted from the IDLE cycle in which the request is seen, with cmd_done=1:
  - Word: ack at cycle 2*WAIT_CYCLES+1.
  - Sub-word: ack at cycle WAIT_CYCLES+1.
  - First access after reset adds 2 cycles.
- Request dropped mid-transaction: the transaction completes and the ack still pulses; the requester ignores it.
- Address or op changes after grant are ignored, because they were latched at grant.
- Misalignment is not checked here; upstream raises the exception and never issues the request.

Decomposition:
- Shared package (defines.v): MEM_* op codes, FLASH_CMD_READ_ARRAY=16'h00FF, state encodings.
- Sub-module flash_load_ext: combinational extractor (op, addr[0], lo, hi → 32-bit data). It is reusable by the SRAM controller.

Test Plan:
- Reset, then IF word read at 0x000100 with flash returning 0x1234 at word addr 0x100 and 0xABCD at 0x102 → CMD_WE pulse with data 0x00FF, then if_rdata_o=0xABCD1234 with ack at cycle 11 (WAIT_CYCLES=4).
- Second IF read at 0x000104 → no command cycles; ack at cycle 9.
- MEM LB at 0x000201, flash halfword 0x80FF → mem_rdata_o=0xFFFFFF80. LBU at the same address → 0x00000080. LH at 0x000200 → 0xFFFF80FF.
- IF and MEM assert in the same cycle after reset → MEM served first. While both are held asserted, grants alternate IF, MEM, IF. pause_o stays 1 throughout.
- rst low during RD_HI → all strobes high and acks 0 immediately. After release, the next access reissues 0x00FF.
- IF drops if_req_i during RD_LO → if_ack_o still pulses once, and the FSM returns to IDLE.
